dual_port_ram_be: RTL and testbench
===================================

# dual_port_ram_be

Parametrised successor to the team's dual-port RAM for single-clock buffering inside the FIFO datapath. Adds per-byte write enables, a registered read path with selectable latency and a `rvalid` strobe, and write-first forwarding on same-address collisions. A hardware clear sequencer sweeps every location to a known value after reset or on request.

## Interface
Parameters:
- `DATA_WIDTH`, 8, word width; must be a multiple of `BYTE_WIDTH`.
- `BYTE_WIDTH`, 8, bits per write-enable lane; `NUM_BYTES = DATA_WIDTH/BYTE_WIDTH`.
- `ADDR_WIDTH`, 3, address width.
- `MEM_SIZE`, `2**ADDR_WIDTH`, number of words; must be ≤ `2**ADDR_WIDTH`.
- `READ_LATENCY`, 1, allowed values 1 or 2.
- `INIT_VALUE`, 0, word value written by the clear sweep.

Ports:
- `clk`  in  1  the only clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  request a full clear sweep; sampled only in RUN.
- `write`  in  1  write strobe.
- `wbe`  in  `NUM_BYTES`  byte-lane enables; lane i covers `wdata[i*BYTE_WIDTH +: BYTE_WIDTH]`.
- `waddr`  in  `ADDR_WIDTH`  write address.
- `wdata`  in  `DATA_WIDTH`  write data.
- `read`  in  1  read request.
- `raddr`  in  `ADDR_WIDTH`  read address.
- `rdata`  out  `DATA_WIDTH`  registered read data; holds its last value between reads and is never tri-stated.
- `rvalid`  out  1  single-cycle strobe marking new `rdata`.
- `busy`  out  1  high during reset and during a clear sweep.

## Operation
- FSM states:
  - INIT: sweep counter `cnt` writes `INIT_VALUE` to `mem[cnt]` and increments each cycle. After writing `MEM_SIZE-1`, go to RUN.
  - RUN: normal access. `clear`=1 sends the FSM to INIT with `cnt`=0.
- In INIT, user `write` and `read` are ignored and no `rvalid` is generated.
- Write (RUN, `write`=1, `waddr` < `MEM_SIZE`): only lanes with `wbe[i]`=1 are updated. `wbe`=0 is a no-op.
- Read accepted when RUN, `read`=1 and `clear`=0.
- Collision (accepted read and write, `raddr`==`waddr`, same edge): returned word is the stored word with the enabled lanes replaced by `wdata` (write-first).
- `READ_LATENCY`=2: only the accept-edge write is forwarded. A write on the following edge is not reflected.
- Out of range (`MEM_SIZE` < `2**ADDR_WIDTH`):
  - a write to an address ≥ `MEM_SIZE` is dropped;
  - a read from an address ≥ `MEM_SIZE` returns `INIT_VALUE` with `rvalid` as normal.
- `clear` accepted in RUN:
  - the read pipeline is flushed, so in-flight reads produce no `rvalid`;
  - a read or write presented on the same edge as `clear` is dropped;
  - `rdata` keeps its value.
- `rst` mid-sweep or mid-read aborts everything and returns all state to its reset value.

## Timing
- While `rst`=1: state INIT, `cnt`=0, `busy`=1, `rvalid`=0, `rdata`=0, pipeline registers 0. Memory contents are not reset directly; the sweep clears them.
- Sweep after `rst` falls: edges 1..`MEM_SIZE` write locations 0..`MEM_SIZE-1`. `busy` falls after edge `MEM_SIZE`, so `busy` is high for exactly `MEM_SIZE` cycles after release.
- Sweep after a `clear` accepted at edge k: `busy` is high from edge k through edge k+`MEM_SIZE`.
- Read accepted at edge k:
  - `READ_LATENCY`=1: `rdata`/`rvalid` update at edge k+1.
  - `READ_LATENCY`=2: they update at edge k+2.
- Back-to-back reads give one `rvalid` per cycle at full throughput.
- A write at edge k is visible to a non-colliding read accepted at edge k+1.

## Structure
- Shared package `dual_port_ram_pkg`: FSM state encoding (`ST_INIT`, `ST_RUN`) and the `NUM_BYTES` derivation as a constant function.
- Sub-module `dpr_storage`:
  - plain array with byte-lane write and asynchronous read port;
  - the top holds the FSM, sweep counter, forwarding merge and latency pipeline.
- Elaboration check: error if `DATA_WIDTH % BYTE_WIDTH` ≠ 0, if `READ_LATENCY` is not 1 or 2, or if `MEM_SIZE` > `2**ADDR_WIDTH`.

## Test plan
- Reset/sweep, defaults: release `rst`, hold `read`=1 at addr 3 → `busy` high for 8 cycles, no `rvalid`. First read after `busy` falls returns 0x00 one cycle later.
- Byte lanes, `DATA_WIDTH`=32: write 0xAABBCCDD with `wbe`=4'b1111, then 0x11223344 with `wbe`=4'b0101 to addr 2; read addr 2 → 0xAA22CC44.
- Collision, `DATA_WIDTH`=32: addr 5 holds 0x12345678; same edge write 0xFFFFFFFF `wbe`=4'b0011 and read addr 5 → `rdata`=0x1234FFFF.
- `READ_LATENCY`=2, reads addr 0..7 on consecutive cycles after writing value=addr: `rvalid` high for 8 consecutive cycles starting 2 edges after the first accept, data 0..7 in order.
- Clear mid-stream, `READ_LATENCY`=2, `INIT_VALUE`=0x5A: issue a read, assert `clear` on the next edge → no `rvalid` for the flushed read, `busy` high for 8 cycles, then every read returns 0x5A.
- Async reset mid-sweep: assert `rst` between edges while sweep `cnt`=4 → `busy`=1, `rvalid`=0, `rdata`=0 immediately. After release the full 8-cycle sweep restarts from address 0.

Source files
------------

// File: rtl/dual_port_ram_be_pkg.sv
// dual_port_ram_pkg
//   Shared definitions for the byte-enable dual-port RAM slice:
//   - state_t   : clear-sequencer FSM states (ST_INIT sweep, ST_RUN access)
//   - num_bytes : number of write-enable lanes for a given word/lane width
package dual_port_ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int unsigned num_bytes(input int unsigned data_width,
                                            input int unsigned byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/dual_port_ram_be_if.sv
// dual_port_ram_be_if
//   Request/response bundle between a RAM client and dual_port_ram_be.
//   master : drives clear, write, wbe, waddr, wdata, read, raddr;
//            observes rdata, rvalid, busy
//   slave  : the RAM side of the same signals
interface dual_port_ram_be_if
  import dual_port_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
);

  localparam int unsigned NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);

  logic                  clear;
  logic                  write;
  logic [NUM_BYTES-1:0]  wbe;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  read;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  busy;

  modport master (
    output clear, write, wbe, waddr, wdata, read, raddr,
    input  rdata, rvalid, busy
  );

  modport slave (
    input  clear, write, wbe, waddr, wdata, read, raddr,
    output rdata, rvalid, busy
  );

endinterface

// File: rtl/dual_port_ram_be_storage.sv
// dpr_storage
//   Plain word array with per-lane synchronous write and asynchronous read.
//   No reset and no range checking: the caller only presents in-range
//   addresses with a non-zero we.
//   clk   : write clock
//   we    : per-lane write enables
//   waddr : write address, wdata : write word
//   raddr : read address,  rdata : combinational read word
module dpr_storage #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned MEM_SIZE   = 8,
  parameter int unsigned NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic [NUM_BYTES-1:0]  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Index width sized to the array so a wider address bus still indexes cleanly.
  localparam int unsigned IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic [IDX_W-1:0]      widx;
  logic [IDX_W-1:0]      ridx;

  assign widx = waddr[IDX_W-1:0];
  assign ridx = raddr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (we[i]) begin
        mem[widx][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be
//   Single-clock dual-port RAM with byte-lane write enables, write-first
//   forwarding on same-address collisions, a 1- or 2-stage registered read
//   path with an rvalid strobe, and a clear sequencer that sweeps INIT_VALUE
//   into every word after reset or on a clear request.
//   clk : clock           rst : asynchronous active-high reset
//   bus : slave side of dual_port_ram_be_if
//         clear/write/wbe/waddr/wdata/read/raddr in, rdata/rvalid/busy out
module dual_port_ram_be
  import dual_port_ram_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           BYTE_WIDTH   = 8,
  parameter int unsigned           ADDR_WIDTH   = 3,
  parameter int unsigned           MEM_SIZE     = 2 ** ADDR_WIDTH,
  parameter int unsigned           READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  dual_port_ram_be_if.slave       bus
);

  localparam int unsigned NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_lanes
    $error("dual_port_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("dual_port_ram_be: READ_LATENCY must be 1 or 2");
  end
  if (MEM_SIZE > 2 ** ADDR_WIDTH) begin : g_bad_size
    $error("dual_port_ram_be: MEM_SIZE exceeds the address space");
  end

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic                  in_run;
  logic                  flush;
  logic                  waddr_ok;
  logic                  raddr_ok;
  logic                  wr_ok;
  logic                  rd_accept;

  logic [NUM_BYTES-1:0]  st_we;
  logic [ADDR_WIDTH-1:0] st_waddr;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [DATA_WIDTH-1:0] st_rdata;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [READ_LATENCY-1:0]                 pipe_v;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] pipe_d;

  assign in_run    = (state_q == ST_RUN);
  assign flush     = in_run && bus.clear;
  assign waddr_ok  = ({1'b0, bus.waddr} < MEM_LIMIT);
  assign raddr_ok  = ({1'b0, bus.raddr} < MEM_LIMIT);
  assign wr_ok     = in_run && bus.write && !bus.clear && waddr_ok;
  assign rd_accept = in_run && bus.read && !bus.clear;
  assign bus.busy  = (state_q == ST_INIT);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state and sweep counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.clear) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage write port: the sweep owns it in INIT, the user in RUN.
  always_comb begin
    st_we    = '0;
    st_waddr = bus.waddr;
    st_wdata = bus.wdata;
    if (!in_run) begin
      st_we    = '1;
      st_waddr = cnt_q;
      st_wdata = INIT_VALUE;
    end else if (wr_ok) begin
      st_we = bus.wbe;
    end
  end

  dpr_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_SIZE   (MEM_SIZE),
    .NUM_BYTES  (NUM_BYTES)
  ) u_storage (
    .clk   (clk),
    .we    (st_we),
    .waddr (st_waddr),
    .wdata (st_wdata),
    .raddr (bus.raddr),
    .rdata (st_rdata)
  );

  // Read word as seen at the accept edge: out-of-range reads return
  // INIT_VALUE, and a same-edge write to the same address is merged lane
  // by lane (write-first). Later writes never reach an in-flight read
  // because the word is captured here.
  always_comb begin
    rd_word = raddr_ok ? st_rdata : INIT_VALUE;
    if (wr_ok && (bus.waddr == bus.raddr)) begin
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        if (bus.wbe[i]) begin
          rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Read pipeline: stage 0 captures at the accept edge, rdata/rvalid load
  // READ_LATENCY edges later. A clear kills every in-flight read and the
  // pending strobe but leaves rdata alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v     <= '0;
      pipe_d     <= '0;
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
    end else if (flush) begin
      pipe_v     <= '0;
      bus.rvalid <= 1'b0;
    end else begin
      pipe_v[0] <= rd_accept;
      if (rd_accept) begin
        pipe_d[0] <= rd_word;
      end
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
      bus.rvalid <= pipe_v[READ_LATENCY-1];
      if (pipe_v[READ_LATENCY-1]) begin
        bus.rdata <= pipe_d[READ_LATENCY-1];
      end
    end
  end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// tb_dual_port_ram_be
//   Directed bench for dual_port_ram_be with two instances:
//   u0 : 8-bit word, 1 lane, 8 words, READ_LATENCY=1, INIT_VALUE=0x00
//   u1 : 32-bit word, 4 lanes, 4-bit address over 8 words,
//        READ_LATENCY=2, INIT_VALUE=0x5A
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_dual_port_ram_be;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  dual_port_ram_be_if #(.DATA_WIDTH(8),  .BYTE_WIDTH(8), .ADDR_WIDTH(3)) if0 ();
  dual_port_ram_be_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4)) if1 ();

  dual_port_ram_be #(
    .DATA_WIDTH   (8),
    .BYTE_WIDTH   (8),
    .ADDR_WIDTH   (3),
    .MEM_SIZE     (8),
    .READ_LATENCY (1),
    .INIT_VALUE   (8'h00)
  ) u0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  dual_port_ram_be #(
    .DATA_WIDTH   (32),
    .BYTE_WIDTH   (8),
    .ADDR_WIDTH   (4),
    .MEM_SIZE     (8),
    .READ_LATENCY (2),
    .INIT_VALUE   (32'h0000_005A)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [2:0] a, input logic [7:0] d, input logic be);
    if0.write = 1'b1; if0.waddr = a; if0.wdata = d; if0.wbe = be;
    step();
    if0.write = 1'b0; if0.wbe = 1'b0;
  endtask

  task automatic rd0(input string tag, input logic [2:0] a, input logic [7:0] exp);
    if0.read = 1'b1; if0.raddr = a;
    step();
    if0.read = 1'b0;
    check({tag, "_v0"}, 32'(if0.rvalid), 32'd0);
    step();
    check({tag, "_v1"}, 32'(if0.rvalid), 32'd1);
    check({tag, "_d"},  32'(if0.rdata),  32'(exp));
  endtask

  task automatic wr1(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    if1.write = 1'b1; if1.waddr = a; if1.wdata = d; if1.wbe = be;
    step();
    if1.write = 1'b0; if1.wbe = 4'h0;
  endtask

  task automatic rd1(input string tag, input logic [3:0] a, input logic [31:0] exp);
    if1.read = 1'b1; if1.raddr = a;
    step();
    if1.read = 1'b0;
    step();
    check({tag, "_v0"}, 32'(if1.rvalid), 32'd0);
    step();
    check({tag, "_v1"}, 32'(if1.rvalid), 32'd1);
    check({tag, "_d"},  if1.rdata, exp);
  endtask

  initial begin
    rst = 1'b1;
    if0.clear = 1'b0; if0.write = 1'b0; if0.wbe = 1'b0; if0.waddr = '0;
    if0.wdata = '0;   if0.read = 1'b0;  if0.raddr = '0;
    if1.clear = 1'b0; if1.write = 1'b0; if1.wbe = 4'h0; if1.waddr = '0;
    if1.wdata = '0;   if1.read = 1'b0;  if1.raddr = '0;
    repeat (3) step();

    check("rst_busy0",  32'(if0.busy),   32'd1);
    check("rst_rvalid0", 32'(if0.rvalid), 32'd0);
    check("rst_rdata0", 32'(if0.rdata),  32'd0);
    check("rst_busy1",  32'(if1.busy),   32'd1);
    check("rst_rvalid1", 32'(if1.rvalid), 32'd0);
    check("rst_rdata1", if1.rdata,       32'd0);

    // Sweep after release with reads held at addr 3: ignored until RUN.
    rst = 1'b0;
    if0.read = 1'b1; if0.raddr = 3'd3;
    if1.read = 1'b1; if1.raddr = 4'd3;
    for (int e = 1; e <= 8; e++) begin
      step();
      check("sweep_busy0", 32'(if0.busy), 32'(e < 8));
      check("sweep_busy1", 32'(if1.busy), 32'(e < 8));
      check("sweep_rv0",   32'(if0.rvalid), 32'd0);
      check("sweep_rv1",   32'(if1.rvalid), 32'd0);
    end
    step();
    if0.read = 1'b0; if1.read = 1'b0;
    check("first_rd_rv0_early", 32'(if0.rvalid), 32'd0);
    step();
    check("first_rd_rv0", 32'(if0.rvalid), 32'd1);
    check("first_rd_d0",  32'(if0.rdata),  32'h00);
    check("first_rd_rv1_early", 32'(if1.rvalid), 32'd0);
    step();
    check("first_rd_rv0_strobe", 32'(if0.rvalid), 32'd0);
    check("first_rd_rv1", 32'(if1.rvalid), 32'd1);
    check("first_rd_d1",  if1.rdata, 32'h0000_005A);
    step();
    check("first_rd_rv1_strobe", 32'(if1.rvalid), 32'd0);

    // u0: write visible to the next-edge read, collisions, swept location.
    wr0(3'd4, 8'h3C, 1'b1);
    rd0("rd_after_wr0", 3'd4, 8'h3C);
    step();
    check("rv0_single", 32'(if0.rvalid), 32'd0);
    if0.write = 1'b1; if0.waddr = 3'd4; if0.wdata = 8'h99; if0.wbe = 1'b1;
    if0.read = 1'b1;  if0.raddr = 3'd4;
    step();
    if0.write = 1'b0; if0.wbe = 1'b0; if0.read = 1'b0;
    step();
    check("coll0_rv", 32'(if0.rvalid), 32'd1);
    check("coll0_d",  32'(if0.rdata),  32'h99);
    if0.write = 1'b1; if0.waddr = 3'd4; if0.wdata = 8'h11; if0.wbe = 1'b0;
    if0.read = 1'b1;  if0.raddr = 3'd4;
    step();
    if0.write = 1'b0; if0.read = 1'b0;
    step();
    check("coll0_nobe_d", 32'(if0.rdata), 32'h99);
    rd0("swept0", 3'd7, 8'h00);

    // u1: byte lanes and a zero-enable write.
    wr1(4'd2, 32'hAABB_CCDD, 4'b1111);
    wr1(4'd2, 32'h1122_3344, 4'b0101);
    rd1("lanes", 4'd2, 32'hAA22_CC44);
    wr1(4'd2, 32'h0000_0000, 4'b0000);
    rd1("wbe_zero", 4'd2, 32'hAA22_CC44);

    // u1: write-first collision, then stored result.
    wr1(4'd5, 32'h1234_5678, 4'b1111);
    if1.write = 1'b1; if1.waddr = 4'd5; if1.wdata = 32'hFFFF_FFFF; if1.wbe = 4'b0011;
    if1.read = 1'b1;  if1.raddr = 4'd5;
    step();
    if1.write = 1'b0; if1.wbe = 4'h0; if1.read = 1'b0;
    step();
    check("coll1_rv_early", 32'(if1.rvalid), 32'd0);
    step();
    check("coll1_rv", 32'(if1.rvalid), 32'd1);
    check("coll1_d",  if1.rdata, 32'h1234_FFFF);

    // u1: a write on the edge after the accept is not forwarded.
    if1.read = 1'b1; if1.raddr = 4'd5;
    step();
    if1.read = 1'b0;
    if1.write = 1'b1; if1.waddr = 4'd5; if1.wdata = 32'hAAAA_AAAA; if1.wbe = 4'hF;
    step();
    if1.write = 1'b0; if1.wbe = 4'h0;
    step();
    check("late_wr_d", if1.rdata, 32'h1234_FFFF);
    rd1("late_wr_stored", 4'd5, 32'hAAAA_AAAA);

    // u1: out-of-range write dropped (no aliasing), read returns INIT_VALUE.
    wr1(4'd9, 32'hDEAD_BEEF, 4'hF);
    rd1("oor_rd", 4'd9, 32'h0000_005A);
    rd1("oor_alias", 4'd1, 32'h0000_005A);

    // u1: back-to-back reads at full throughput.
    for (int a = 0; a < 8; a++) wr1(4'(a), 32'(a), 4'hF);
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        if1.read = 1'b1; if1.raddr = 4'(c);
      end else begin
        if1.read = 1'b0;
      end
      step();
      if (c >= 2) begin
        check("stream_v", 32'(if1.rvalid), 32'd1);
        check("stream_d", if1.rdata, 32'(c - 2));
      end else begin
        check("stream_v", 32'(if1.rvalid), 32'd0);
      end
    end
    step();
    check("stream_end_v", 32'(if1.rvalid), 32'd0);

    // u1: clear on the edge after a read accept flushes it; a read on the
    // clear edge is dropped; rdata holds.
    if1.read = 1'b1; if1.raddr = 4'd3;
    step();
    if1.clear = 1'b1; if1.read = 1'b1; if1.raddr = 4'd2;
    step();
    if1.clear = 1'b0; if1.read = 1'b0;
    check("clr_busy", 32'(if1.busy), 32'd1);
    check("clr_rv",   32'(if1.rvalid), 32'd0);
    for (int e = 1; e <= 8; e++) begin
      step();
      check("clr_sweep_busy", 32'(if1.busy), 32'(e < 8));
      check("clr_sweep_rv",   32'(if1.rvalid), 32'd0);
    end
    check("clr_rdata_hold", if1.rdata, 32'd7);
    for (int a = 0; a < 8; a++) rd1("clr_val", 4'(a), 32'h0000_005A);

    // Async reset in the middle of a clear sweep (cnt = 4).
    wr0(3'd6, 8'hE7, 1'b1);
    rd0("pre_rst0", 3'd6, 8'hE7);
    if0.clear = 1'b1; if1.clear = 1'b1;
    step();
    if0.clear = 1'b0; if1.clear = 1'b0;
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    check("midrst_busy0", 32'(if0.busy),   32'd1);
    check("midrst_rv0",   32'(if0.rvalid), 32'd0);
    check("midrst_d0",    32'(if0.rdata),  32'd0);
    check("midrst_busy1", 32'(if1.busy),   32'd1);
    check("midrst_d1",    if1.rdata,       32'd0);
    step();
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      check("resweep_busy0", 32'(if0.busy), 32'(e < 8));
      check("resweep_busy1", 32'(if1.busy), 32'(e < 8));
    end
    rd0("resweep_a6", 3'd6, 8'h00);
    rd1("resweep_a7", 4'd7, 32'h0000_005A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
